// File: rtl/micro_sequencer.sv
// Microprogram sequencer: micro-PC next-address selection, undefined-instruction
// exception parking, and instruction/cycle counters for CPI measurement.
module micro_sequencer #(
   parameter int UPC_W       = 5,
   parameter int FETCH_STATE = 0,
   parameter int EXC_STATE   = 31,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       addr_ctl,
   input  logic [UPC_W-1:0] next_state_dt1,
   input  logic [UPC_W-1:0] next_state_dt2,
   input  logic             stall,
   input  logic             exc_ack,
   output logic [UPC_W-1:0] upc,
   output logic             fetch,
   output logic             exc_pending,
   output logic [UPC_W-1:0] exc_upc,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_STATE);
   localparam logic [UPC_W-1:0] EXC_UPC   = UPC_W'(EXC_STATE);
   localparam logic [UPC_W-1:0] UPC_ONE   = UPC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [1:0] AC_FETCH = 2'b00;
   localparam logic [1:0] AC_DT1   = 2'b01;
   localparam logic [1:0] AC_DT2   = 2'b10;
   localparam logic [1:0] AC_SEQ   = 2'b11;

   logic [UPC_W-1:0] upc_q, upc_d;
   logic             exc_pending_q, exc_pending_d;
   logic [UPC_W-1:0] exc_upc_q, exc_upc_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic [UPC_W-1:0] sel_upc_s;
   logic             in_exc_s;

   // Next-address mux driven by the ROM's address-control field
   always_comb begin
      sel_upc_s = FETCH_UPC;
      case (addr_ctl)
         AC_FETCH: sel_upc_s = FETCH_UPC;
         AC_DT1:   sel_upc_s = next_state_dt1;
         AC_DT2:   sel_upc_s = next_state_dt2;
         AC_SEQ:   sel_upc_s = upc_q + UPC_ONE;
         default:  sel_upc_s = FETCH_UPC;
      endcase
   end

   assign in_exc_s = (upc_q == EXC_UPC);

   // Sequencing, exception entry/exit and retirement; stall freezes all but the cycle counter
   always_comb begin
      upc_d         = upc_q;
      exc_pending_d = exc_pending_q;
      exc_upc_d     = exc_upc_q;
      instr_count_d = instr_count_q;
      cycle_count_d = cycle_count_q + CNT_ONE;
      if (stall) begin
         upc_d = upc_q;
      end else if (in_exc_s) begin
         if (exc_ack) begin
            upc_d         = FETCH_UPC;
            exc_pending_d = 1'b0;
         end else begin
            upc_d = upc_q;
         end
      end else begin
         upc_d = sel_upc_s;
         if (sel_upc_s == EXC_UPC) begin
            exc_pending_d = 1'b1;
            exc_upc_d     = upc_q;
         end else begin
            exc_pending_d = exc_pending_q;
         end
         if (addr_ctl == AC_FETCH) begin
            instr_count_d = instr_count_q + CNT_ONE;
         end else begin
            instr_count_d = instr_count_q;
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upc_q         <= FETCH_UPC;
         exc_pending_q <= 1'b0;
         exc_upc_q     <= {UPC_W{1'b0}};
         instr_count_q <= {CNT_W{1'b0}};
         cycle_count_q <= {CNT_W{1'b0}};
      end else begin
         upc_q         <= upc_d;
         exc_pending_q <= exc_pending_d;
         exc_upc_q     <= exc_upc_d;
         instr_count_q <= instr_count_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign upc         = upc_q;
   assign fetch       = (upc_q == FETCH_UPC);
   assign exc_pending = exc_pending_q;
   assign exc_upc     = exc_upc_q;
   assign instr_count = instr_count_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr_ctl;
   logic [4:0]  next_state_dt1;
   logic [4:0]  next_state_dt2;
   logic        stall;
   logic        exc_ack;
   logic [4:0]  upc;
   logic        fetch;
   logic        exc_pending;
   logic [4:0]  exc_upc;
   logic [31:0] instr_count;
   logic [31:0] cycle_count;

   micro_sequencer #(
      .UPC_W(5), .FETCH_STATE(0), .EXC_STATE(31), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .addr_ctl(addr_ctl),
      .next_state_dt1(next_state_dt1), .next_state_dt2(next_state_dt2),
      .stall(stall), .exc_ack(exc_ack), .upc(upc), .fetch(fetch),
      .exc_pending(exc_pending), .exc_upc(exc_upc),
      .instr_count(instr_count), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [4:0]  upc;
      logic        fetch;
      logic        pend;
      logic [4:0]  eupc;
      logic [31:0] ic;
      logic [31:0] cc;
   } exp_t;

   exp_t        exp_q[$];
   int          nvec  = 0;
   int          nfail = 0;
   logic [31:0] cyc   = 32'd0;

   task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
      end
   endtask

   task automatic step(input logic [1:0] ac, input logic [4:0] d1, input logic [4:0] d2,
                       input logic st, input logic ack);
      addr_ctl       = ac;
      next_state_dt1 = d1;
      next_state_dt2 = d2;
      stall          = st;
      exc_ack        = ack;
      @(posedge clk);
      #1;
      cyc = cyc + 32'd1;
   endtask

   task automatic expect_state(input string tag, input logic [4:0] u, input logic p,
                               input logic [4:0] eu, input logic [31:0] ic);
      exp_t e;
      e.tag = tag; e.upc = u; e.fetch = (u == 5'd0); e.pend = p;
      e.eupc = eu; e.ic = ic; e.cc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic check_front();
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.tag, "upc",   32'(upc),         32'(e.upc));
      cmp(e.tag, "fetch", 32'(fetch),       32'(e.fetch));
      cmp(e.tag, "pend",  32'(exc_pending), 32'(e.pend));
      cmp(e.tag, "eupc",  32'(exc_upc),     32'(e.eupc));
      cmp(e.tag, "ic",    instr_count,      e.ic);
      cmp(e.tag, "cc",    cycle_count,      e.cc);
   endtask

   initial begin
      reset = 1'b1; addr_ctl = 2'b00; next_state_dt1 = 5'd0; next_state_dt2 = 5'd0;
      stall = 1'b0; exc_ack = 1'b0;
      #12 reset = 1'b0;
      expect_state("reset", 5'd0, 1'b0, 5'd0, 32'd0); check_front();

      // sequential increments
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("seq1", 5'd1, 1'b0, 5'd0, 32'd0); check_front();
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("seq2", 5'd2, 1'b0, 5'd0, 32'd0); check_front();
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("seq3", 5'd3, 1'b0, 5'd0, 32'd0); check_front();
      step(2'b00, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("fetch1", 5'd0, 1'b0, 5'd0, 32'd1); check_front();

      // dispatch tables
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("to1", 5'd1, 1'b0, 5'd0, 32'd1); check_front();
      step(2'b01, 5'd12, 5'd7, 1'b0, 1'b0); expect_state("dt1", 5'd12, 1'b0, 5'd0, 32'd1); check_front();
      step(2'b00, 5'd3, 5'd3, 1'b0, 1'b0); expect_state("fetch2", 5'd0, 1'b0, 5'd0, 32'd2); check_front();
      step(2'b10, 5'd9, 5'd20, 1'b0, 1'b0); expect_state("dt2", 5'd20, 1'b0, 5'd0, 32'd2); check_front();
      step(2'b00, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("fetch3", 5'd0, 1'b0, 5'd0, 32'd3); check_front();

      // stall freezes everything but cycle_count
      step(2'b01, 5'd16, 5'd0, 1'b0, 1'b0); expect_state("to16", 5'd16, 1'b0, 5'd0, 32'd3); check_front();
      for (int i = 0; i < 5; i++) begin
         step(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
         expect_state("stall", 5'd16, 1'b0, 5'd0, 32'd3); check_front();
      end
      step(2'b00, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("unstall", 5'd0, 1'b0, 5'd0, 32'd4); check_front();

      // exception via dispatch-1, held until ack
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("to1b", 5'd1, 1'b0, 5'd0, 32'd4); check_front();
      step(2'b01, 5'd31, 5'd0, 1'b0, 1'b0); expect_state("exc_in", 5'd31, 1'b1, 5'd1, 32'd4); check_front();
      for (int i = 0; i < 3; i++) begin
         step(2'b00, 5'd5, 5'd6, 1'b0, 1'b0);
         expect_state("exc_hold", 5'd31, 1'b1, 5'd1, 32'd4); check_front();
      end
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b1); expect_state("exc_ack", 5'd0, 1'b0, 5'd1, 32'd4); check_front();

      // exception via sequential from 30; ack lost under stall
      step(2'b01, 5'd30, 5'd0, 1'b0, 1'b0); expect_state("to30", 5'd30, 1'b0, 5'd1, 32'd4); check_front();
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("seq_exc", 5'd31, 1'b1, 5'd30, 32'd4); check_front();
      step(2'b00, 5'd0, 5'd0, 1'b1, 1'b1); expect_state("ack_stall", 5'd31, 1'b1, 5'd30, 32'd4); check_front();
      step(2'b00, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("ack_lost", 5'd31, 1'b1, 5'd30, 32'd4); check_front();
      step(2'b00, 5'd0, 5'd0, 1'b0, 1'b1); expect_state("ack2", 5'd0, 1'b0, 5'd30, 32'd4); check_front();
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b1); expect_state("ack_noexc", 5'd1, 1'b0, 5'd30, 32'd4); check_front();

      // asynchronous reset mid-operation
      step(2'b01, 5'd12, 5'd0, 1'b0, 1'b0); expect_state("to12", 5'd12, 1'b0, 5'd30, 32'd4); check_front();
      #3 reset = 1'b1;
      #1 cyc = 32'd0;
      expect_state("async_rst", 5'd0, 1'b0, 5'd0, 32'd0); check_front();
      #1 reset = 1'b0;
      step(2'b00, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("post_rst", 5'd0, 1'b0, 5'd0, 32'd1); check_front();
      step(2'b11, 5'd0, 5'd0, 1'b0, 1'b0); expect_state("post_rst2", 5'd1, 1'b0, 5'd0, 32'd1); check_front();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
